mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store sequencer that sits directly upstream of the 32-bit byte-addressable data RAM (18-bit byte address, 4 byte lanes, unaligned-capable).
- Accepts one CPU memory request at a time over a valid/ready handshake.
- Drives the RAM port and waits out the RAM's one-cycle synchronous read latency.
- Sign- or zero-extends load data and returns a registered response over a second valid/ready handshake with backpressure.

Parameters:
- ADDR_W, 18, byte-address width; matches the RAM address port.
- ADDR_LIMIT, 2**18 - 1, highest legal byte address; used only when MEM_RANGE_CHECK_EN is defined.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_address  in  ADDR_W  byte address; any alignment.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  request was not performed.
- ram_address  out  ADDR_W  to RAM address.
- ram_data_in  out  32  to RAM data_in.
- ram_byte_enablers  out  4  to RAM byte_enablers.
- ram_write_enable  out  1  to RAM write_enable.
- ram_data_out  in  32  from RAM data_out; valid one cycle after address is presented.

Behaviour:
- Reset value of every output is 0 while reset_n is low at an edge, except req_ready, which is 1 after reset.
- Reset: state goes to IDLE and the request/response registers clear.
- ram_write_enable is additionally gated by reset_n, so no write occurs at an edge where reset_n = 0, including mid-ISSUE.
- FSM states: IDLE, ISSUE, CAPTURE, RESPOND.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch write, size, unsigned, address and wdata into the request register; go to ISSUE.
  - If size == 11, latch an error flag instead and go straight to RESPOND. No RAM access occurs.
- ISSUE:
  - ram_address = latched address.
  - ram_byte_enablers: 0001 for byte, 0011 for half, 1111 for word. The RAM performs the lane rotation.
  - ram_data_in = latched wdata.
  - ram_write_enable = latched write.
  - Stores go to RESPOND; loads go to CAPTURE.
- CAPTURE:
  - Address held and write_enable = 0.
  - Extend ram_data_out: byte uses bit 7, half uses bit 15, word passes through; unsigned forces zero-fill.
  - Register the result into resp_rdata; go to RESPOND.
- RESPOND:
  - resp_valid = 1; resp_rdata and resp_error stay stable until the handshake.
  - On resp_ready, go to IDLE.
  - req_ready stays 0 outside IDLE; requests are never accepted in the same cycle as a response handshake.
- Latency from request acceptance edge to resp_valid high:
  - load: 3 cycles.
  - store: 2 cycles.
  - error: 1 cycle.
- Minimum spacing between accepted requests is latency + 1 cycle.
- Outside ISSUE/CAPTURE, ram_* outputs hold their last address/data, with write_enable = 0 and byte_enablers = 0000.
- Address wrap-around is delegated to the RAM; this unit does no address arithmetic.

Optional Feature:
- MEM_RANGE_CHECK_EN defined:
  - In IDLE, a request is out of range if address + bytes(size) - 1 > ADDR_LIMIT, computed ADDR_W+1 bits wide.
  - An out-of-range request goes directly to RESPOND with resp_error = 1 and resp_rdata = 0, and never asserts ram_write_enable.
- Not defined: no check; only size == 11 produces an error.

Decomposition:
- Package mem_access_pkg holds:
  - size_t enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_ILLEGAL).
  - state_t enum.
  - Byte-enable constants BE_BYTE, BE_HALF, BE_WORD.
- One combinational sub-module, load_extender (size, unsigned, raw 32-bit in → extended 32-bit out), shared with future loaders.

Test Plan:
- Reset mid-store:
  - Stimulus: pull reset_n low during ISSUE of a store.
  - Required: ram_write_enable = 0 at that edge; RAM word unchanged; after reset, req_ready = 1 and resp_valid = 0.
- Store then load, word:
  - Stimulus: store word 0xDEADBEEF at address 0x00006, then load word at 0x00006.
  - Required: resp_rdata = 0xDEADBEEF, resp_error = 0, resp_valid exactly 3 cycles after the load is accepted.
- Byte loads, signed vs unsigned:
  - Stimulus: store byte 0x80 at 0x00011; load signed byte, then unsigned byte.
  - Required: resp_rdata = 0xFFFFFF80, then 0x00000080; the store drives ram_byte_enablers = 0001.
- Half-word sign extension:
  - Stimulus: load signed half from an address holding 0x7FFF, then one holding 0x8001.
  - Required: 0x00007FFF, then 0xFFFF8001.
- Response backpressure:
  - Stimulus: hold resp_ready = 0 for 5 cycles after resp_valid rises.
  - Required: resp_rdata stable, req_ready = 0 throughout, no RAM activity; handshake completes on the first resp_ready = 1.
- Illegal size:
  - Stimulus: req_size = 11, req_write = 1.
  - Required: resp_error = 1 the next cycle, ram_write_enable never high.
  - With MEM_RANGE_CHECK_EN and ADDR_LIMIT = 0x3FFFF: word access at 0x3FFFE also returns resp_error = 1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store sequencer.
// Size encodings, FSM state encoding, RAM byte-enable patterns and
// small size-decoding helpers used by mem_access_unit and load_extender.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESPOND = 2'b11
  } state_t;

  // The RAM rotates lanes itself, so enables are always right-justified.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic [3:0] be_for_size(input size_t s);
    case (s)
      SIZE_BYTE: return BE_BYTE;
      SIZE_HALF: return BE_HALF;
      SIZE_WORD: return BE_WORD;
      default:   return 4'b0000;
    endcase
  endfunction

  // Offset of the last byte touched by an access (bytes(size) - 1).
  function automatic logic [1:0] last_offset(input size_t s);
    case (s)
      SIZE_BYTE: return 2'd0;
      SIZE_HALF: return 2'd1;
      default:   return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// load_extender: combinational sign/zero extension of raw RAM read data.
// Byte loads extend from bit 7, half loads from bit 15, words pass through.
module load_extender
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  logic signed [7:0]  raw_b;
  logic signed [15:0] raw_h;

  assign raw_b = signed'(raw[7:0]);
  assign raw_h = signed'(raw[15:0]);

  // Select the extension according to access size and signedness
  always_comb begin
    ext = raw;
    case (size_t'(size))
      SIZE_BYTE: ext = is_unsigned ? {24'h000000, raw[7:0]}  : {{24{raw_b[7]}}, raw_b};
      SIZE_HALF: ext = is_unsigned ? {16'h0000,   raw[15:0]} : {{16{raw_h[15]}}, raw_h};
      default:   ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store sequencer in front of the
// 32-bit byte-addressable data RAM (one-cycle synchronous read latency).
// Optional build macro MEM_RANGE_CHECK_EN: rejects accesses whose last
// byte lies beyond ADDR_LIMIT; without it only size 2'b11 is an error.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int          ADDR_W     = 18,
  parameter int unsigned ADDR_LIMIT = 2**18 - 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_data_in,
  output logic [3:0]        ram_byte_enablers,
  output logic              ram_write_enable,
  input  logic [31:0]       ram_data_out
);

  // Catch a limit that cannot be expressed on the address bus
  if (ADDR_LIMIT > (2**ADDR_W) - 1) begin : g_limit_check
    $error("ADDR_LIMIT exceeds the ADDR_W address space");
  end

  state_t              state;
  logic                req_write_q;
  size_t               req_size_q;
  logic                req_unsigned_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [31:0]         req_wdata_q;
  logic [31:0]         rdata_q;
  logic                error_q;
  logic [31:0]         ext_data;
  logic                illegal;
  logic                accept_err;

  assign illegal = (size_t'(req_size) == SIZE_ILLEGAL);

`ifdef MEM_RANGE_CHECK_EN
  localparam logic [ADDR_W:0] LIMIT = ADDR_LIMIT[ADDR_W:0];
  logic [ADDR_W:0] last_byte;

  // One extra bit so an access running past the top of memory is visible
  assign last_byte  = {1'b0, req_address}
                    + {{(ADDR_W-1){1'b0}}, last_offset(size_t'(req_size))};
  assign accept_err = illegal | (last_byte > LIMIT);
`else
  assign accept_err = illegal;
`endif

  load_extender u_ext (
    .size        (req_size_q),
    .is_unsigned (req_unsigned_q),
    .raw         (ram_data_out),
    .ext         (ext_data)
  );

  // Sequencer state, latched request and registered response
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      req_write_q    <= 1'b0;
      req_size_q     <= SIZE_BYTE;
      req_unsigned_q <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      rdata_q        <= '0;
      error_q        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rdata_q <= '0;
            error_q <= accept_err;
            if (accept_err) begin
              // Rejected requests never touch the RAM port registers.
              state <= ST_RESPOND;
            end else begin
              req_write_q    <= req_write;
              req_size_q     <= size_t'(req_size);
              req_unsigned_q <= req_unsigned;
              req_addr_q     <= req_address;
              req_wdata_q    <= req_wdata;
              state          <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE:   state <= req_write_q ? ST_RESPOND : ST_CAPTURE;
        ST_CAPTURE: begin
          rdata_q <= ext_data;
          state   <= ST_RESPOND;
        end
        ST_RESPOND: if (resp_ready) state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state == ST_IDLE);
  assign resp_valid  = (state == ST_RESPOND);
  assign resp_rdata  = rdata_q;
  assign resp_error  = error_q;
  assign ram_address = req_addr_q;
  assign ram_data_in = req_wdata_q;

  // RAM strobes: enables during ISSUE/CAPTURE, write only in ISSUE and never while reset is low
  always_comb begin
    ram_byte_enablers = 4'b0000;
    ram_write_enable  = 1'b0;
    if (state == ST_ISSUE || state == ST_CAPTURE) begin
      ram_byte_enablers = be_for_size(req_size_q);
    end
    if (state == ST_ISSUE) begin
      ram_write_enable = req_write_q & reset_n;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural byte RAM.
// Expected responses are queued when a request is accepted and popped
// when the response handshake happens.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int ADDR_W = 18;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_address = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic              resp_error;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_data_in;
  logic [3:0]        ram_byte_enablers;
  logic              ram_write_enable;
  logic [31:0]       ram_data_out;

  int n_vec = 0;
  int n_miss = 0;
  int we_count = 0;

  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always #5 clock = ~clock;

  mem_access_unit #(.ADDR_W(ADDR_W), .ADDR_LIMIT(32'h3FFFF)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_size          (req_size),
    .req_unsigned      (req_unsigned),
    .req_address       (req_address),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .resp_error        (resp_error),
    .ram_address       (ram_address),
    .ram_data_in       (ram_data_in),
    .ram_byte_enablers (ram_byte_enablers),
    .ram_write_enable  (ram_write_enable),
    .ram_data_out      (ram_data_out)
  );

  // Behavioural RAM: little-endian, lane rotation done here, 1-cycle read
  always @(posedge clock) begin
    ram_data_out <= {mem[ram_address + 18'd3], mem[ram_address + 18'd2],
                     mem[ram_address + 18'd1], mem[ram_address]};
    if (ram_write_enable) begin
      we_count <= we_count + 1;
      for (int i = 0; i < 4; i++)
        if (ram_byte_enablers[i]) mem[ram_address + 18'(i)] <= ram_data_in[8*i +: 8];
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Drive a request from a negedge; returns at the first negedge after acceptance.
  task automatic send_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [31:0] xrd, input logic xer);
    int waitc = 0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_address = a; req_wdata = d;
    while (!req_ready && waitc < 50) begin
      @(negedge clock);
      waitc++;
    end
    if (!req_ready) begin
      n_vec++; n_miss++;
      $display("FAIL req_accept_timeout req_ready got %b want 1", req_ready);
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    exp_rdata_q.push_back(xrd);
    exp_err_q.push_back(xer);
  endtask

  // Wait for a response, complete the handshake, and hand back observed and expected values.
  task automatic get_resp(output logic [31:0] rd, output logic er, output int lat,
                          output logic [31:0] xrd, output logic xer);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    rd = resp_rdata; er = resp_error;
    if (exp_rdata_q.size() > 0) begin
      xrd = exp_rdata_q.pop_front();
      xer = exp_err_q.pop_front();
    end else begin
      xrd = 32'hxxxxxxxx; xer = 1'bx;
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    n_vec++;
    if (req_ready !== 1'b1) begin n_miss++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_vec++;
    if ({resp_valid, resp_error, resp_rdata} !== 34'd0) begin
      n_miss++; $display("FAIL rst_resp got v=%b e=%b d=%h want 0", resp_valid, resp_error, resp_rdata);
    end
    n_vec++;
    if ({ram_address, ram_data_in, ram_byte_enablers, ram_write_enable} !== 55'd0) begin
      n_miss++; $display("FAIL rst_ram got a=%h d=%h be=%b we=%b want 0", ram_address, ram_data_in,
                         ram_byte_enablers, ram_write_enable);
    end
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_store_load_word();
    logic [31:0] rd, xrd; logic er, xer; int lat;
    send_req(1'b1, 2'b10, 1'b0, 18'h00006, 32'hDEADBEEF, 32'h0, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if (lat !== 2) begin n_miss++; $display("FAIL sw_latency got %0d want 2", lat); end
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL sw_resp got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
    send_req(1'b0, 2'b10, 1'b0, 18'h00006, 32'h0, 32'hDEADBEEF, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if (lat !== 3) begin n_miss++; $display("FAIL lw_latency got %0d want 3", lat); end
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL lw_resp got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
  endtask

  task automatic test_byte_loads();
    logic [31:0] rd, xrd; logic er, xer; int lat;
    send_req(1'b1, 2'b00, 1'b0, 18'h00011, 32'hABCDEF80, 32'h0, 1'b0);
    n_vec++;
    if ({ram_byte_enablers, ram_write_enable} !== 5'b0001_1) begin
      n_miss++; $display("FAIL sb_strobes got be=%b we=%b want be=0001 we=1", ram_byte_enablers, ram_write_enable);
    end
    n_vec++;
    if (ram_address !== 18'h00011) begin n_miss++; $display("FAIL sb_address got %h want 00011", ram_address); end
    get_resp(rd, er, lat, xrd, xer);
    send_req(1'b0, 2'b00, 1'b0, 18'h00011, 32'h0, 32'hFFFFFF80, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL lb_signed got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
    send_req(1'b0, 2'b00, 1'b1, 18'h00011, 32'h0, 32'h00000080, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL lb_unsigned got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
  endtask

  task automatic test_half_sign();
    logic [31:0] rd, xrd; logic er, xer; int lat;
    send_req(1'b1, 2'b01, 1'b0, 18'h00100, 32'h55557FFF, 32'h0, 1'b0);
    n_vec++;
    if (ram_byte_enablers !== 4'b0011) begin n_miss++; $display("FAIL sh_be got %b want 0011", ram_byte_enablers); end
    get_resp(rd, er, lat, xrd, xer);
    send_req(1'b1, 2'b01, 1'b0, 18'h00103, 32'h12348001, 32'h0, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    send_req(1'b0, 2'b01, 1'b0, 18'h00100, 32'h0, 32'h00007FFF, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL lh_pos got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
    send_req(1'b0, 2'b01, 1'b0, 18'h00103, 32'h0, 32'hFFFF8001, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL lh_neg got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
    send_req(1'b0, 2'b01, 1'b1, 18'h00103, 32'h0, 32'h00008001, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL lhu_neg got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, xrd; logic er, xer; int lat; int we_before;
    send_req(1'b1, 2'b10, 1'b0, 18'h00020, 32'h55AA33CC, 32'h0, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    send_req(1'b0, 2'b10, 1'b0, 18'h00020, 32'h0, 32'h55AA33CC, 1'b0);
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clock); lat++; end
    xrd = exp_rdata_q.pop_front(); xer = exp_err_q.pop_front();
    we_before = we_count;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({resp_valid, req_ready, resp_error, resp_rdata} !== {1'b1, 1'b0, xer, xrd}) begin
        n_miss++; $display("FAIL bp_hold[%0d] got v=%b rdy=%b e=%b d=%h want v=1 rdy=0 e=%b d=%h", i,
                           resp_valid, req_ready, resp_error, resp_rdata, xer, xrd);
      end
      n_vec++;
      if ({ram_byte_enablers, ram_write_enable} !== 5'd0) begin
        n_miss++; $display("FAIL bp_ram_idle[%0d] got be=%b we=%b want 0", i, ram_byte_enablers, ram_write_enable);
      end
      @(negedge clock);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    n_vec++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_miss++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", resp_valid, req_ready);
    end
    n_vec++;
    if (we_count !== we_before) begin n_miss++; $display("FAIL bp_no_write got %0d writes want 0", we_count - we_before); end
  endtask

  task automatic test_illegal();
    logic [31:0] rd, xrd; logic er, xer; int lat; int we_before;
    we_before = we_count;
    send_req(1'b1, 2'b11, 1'b0, 18'h00006, 32'hFFFFFFFF, 32'h0, 1'b1);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if (lat !== 1) begin n_miss++; $display("FAIL ill_latency got %0d want 1", lat); end
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL ill_resp got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
    n_vec++;
    if (we_count !== we_before) begin n_miss++; $display("FAIL ill_no_write got %0d writes want 0", we_count - we_before); end
    send_req(1'b0, 2'b10, 1'b0, 18'h00006, 32'h0, 32'hDEADBEEF, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL ill_ram_intact got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
  endtask

  task automatic test_top_of_memory();
    logic [31:0] rd, xrd; logic er, xer; int lat; int we_before;
    send_req(1'b1, 2'b10, 1'b0, 18'h3FFFC, 32'hCAFEF00D, 32'h0, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    send_req(1'b1, 2'b10, 1'b0, 18'h00000, 32'h12345678, 32'h0, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
`ifdef MEM_RANGE_CHECK_EN
    send_req(1'b0, 2'b10, 1'b0, 18'h3FFFE, 32'h0, 32'h0, 1'b1);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if (lat !== 1) begin n_miss++; $display("FAIL oor_latency got %0d want 1", lat); end
    we_before = we_count;
    send_req(1'b1, 2'b01, 1'b0, 18'h3FFFF, 32'h0000BBBB, 32'h0, 1'b1);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if (we_count !== we_before) begin n_miss++; $display("FAIL oor_no_write got %0d writes want 0", we_count - we_before); end
`else
    we_before = we_count;
    send_req(1'b0, 2'b10, 1'b0, 18'h3FFFE, 32'h0, 32'h5678CAFE, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if (lat !== 3) begin n_miss++; $display("FAIL wrap_latency got %0d want 3", lat); end
    n_vec++;
    if (we_count !== we_before) begin n_miss++; $display("FAIL wrap_no_write got %0d writes want 0", we_count - we_before); end
`endif
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL top_resp got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] rd, xrd; logic er, xer; int lat;
    send_req(1'b1, 2'b10, 1'b0, 18'h00040, 32'h11223344, 32'h0, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    send_req(1'b1, 2'b10, 1'b0, 18'h00040, 32'hAAAAAAAA, 32'h0, 1'b0);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (ram_write_enable !== 1'b0) begin n_miss++; $display("FAIL rms_we got %b want 0", ram_write_enable); end
    @(posedge clock);
    @(negedge clock);
    n_vec++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      n_miss++; $display("FAIL rms_after got rdy=%b v=%b want rdy=1 v=0", req_ready, resp_valid);
    end
    reset_n = 1'b1;
    void'(exp_rdata_q.pop_front());
    void'(exp_err_q.pop_front());
    @(negedge clock);
    n_vec++;
    if ({mem[18'h43], mem[18'h42], mem[18'h41], mem[18'h40]} !== 32'h11223344) begin
      n_miss++; $display("FAIL rms_ram got %h want 11223344",
                         {mem[18'h43], mem[18'h42], mem[18'h41], mem[18'h40]});
    end
    send_req(1'b0, 2'b10, 1'b0, 18'h00040, 32'h0, 32'h11223344, 1'b0);
    get_resp(rd, er, lat, xrd, xer);
    n_vec++;
    if ({er, rd} !== {xer, xrd}) begin n_miss++; $display("FAIL rms_load got e=%b d=%h want e=%b d=%h", er, rd, xer, xrd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, xrd; logic er, xer; int lat;
    logic [31:0] words [4];
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom;
      send_req(1'b1, 2'b10, 1'b0, 18'h00200 + 18'(4*i), words[i], 32'h0, 1'b0);
      get_resp(rd, er, lat, xrd, xer);
    end
    for (int i = 0; i < 4; i++) begin
      send_req(1'b0, 2'b10, 1'b0, 18'h00200 + 18'(4*i), 32'h0, words[i], 1'b0);
      get_resp(rd, er, lat, xrd, xer);
      n_vec++;
      if ({er, rd} !== {xer, xrd} || lat !== 3) begin
        n_miss++; $display("FAIL b2b_load[%0d] got e=%b d=%h lat=%0d want e=%b d=%h lat=3", i, er, rd, lat, xer, xrd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load_word();
    test_byte_loads();
    test_half_sign();
    test_backpressure();
    test_illegal();
    test_top_of_memory();
    test_reset_mid_store();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
